// File: rtl/nibble_sequence_detector_pkg.sv
// Shared types for the nibble sequence detector: nibble type, FSM state encoding
// (number of pattern nibbles matched so far) and the default pattern.
package seq_det_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  localparam nibble_t DEF_PAT [4] = '{4'ha, 4'hb, 4'hc, 4'hd};

endpackage

// File: rtl/nibble_sequence_detector_if.sv
// Bundle of the detector's stream input, flush control and status outputs.
// in_valid qualifies in_data on each rising clock edge; there is no back-pressure,
// so a nibble is consumed on every edge where in_valid=1 and in_data is ignored otherwise.
interface nibble_sequence_detector_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic [1:0]       state;

  modport master (
    output in_valid, in_data, clear,
    input  match, match_count, count_sat, state
  );

  modport slave (
    input  in_valid, in_data, clear,
    output match, match_count, count_sat, state
  );
endinterface

// File: rtl/nibble_sequence_detector_next_state.sv
// Combinational KMP-style transition: advance on the expected nibble, otherwise fall
// back to the longest pattern prefix that is a suffix of (matched prefix ++ in_data).
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int W = 4
) (
  input  det_state_t          i_state,
  input  logic [W-1:0]        i_data,
  input  logic [3:0][W-1:0]   i_pattern,
  output det_state_t          o_next_state,
  output logic                o_hit
);

  logic         w_found;
  logic         w_ok;
  logic [W-1:0] w_sym;

  always_comb begin
    o_next_state = S0;
    o_hit        = 1'b0;
    w_found      = 1'b0;
    w_ok         = 1'b0;
    w_sym        = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(i_state) == k) begin
        if (k < 3 && i_data == i_pattern[k]) begin
          o_next_state = det_state_t'(2'(k + 1));
        end else begin
          // A full match uses the same search: the longest proper border of the pattern.
          if (k == 3 && i_data == i_pattern[3]) o_hit = 1'b1;
          for (int j = k; j >= 1; j--) begin
            w_ok = 1'b1;
            for (int m = 0; m < j; m++) begin
              w_sym = (k + 1 - j + m == k) ? i_data : i_pattern[k + 1 - j + m];
              if (w_sym != i_pattern[m]) w_ok = 1'b0;
            end
            if (w_ok && !w_found) begin
              o_next_state = det_state_t'(2'(j));
              w_found      = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/nibble_sequence_detector.sv
// Detects a programmable 4-nibble pattern with overlap; registers a 1-cycle match
// pulse, a saturating match counter, a sticky saturation flag and the FSM state.
module nibble_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int           W     = 4,
  parameter logic [W-1:0] PAT0  = DEF_PAT[0],
  parameter logic [W-1:0] PAT1  = DEF_PAT[1],
  parameter logic [W-1:0] PAT2  = DEF_PAT[2],
  parameter logic [W-1:0] PAT3  = DEF_PAT[3],
  parameter int           CNT_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  nibble_sequence_detector_if.slave     bus
);

  localparam logic [3:0][W-1:0]  PATTERN  = {PAT3, PAT2, PAT1, PAT0};
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_NEAR = CNT_MAX - CNT_W'(1);

  det_state_t       r_state;
  logic             r_match;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  det_state_t       w_next_state;
  logic             w_hit;

  seq_det_next_state #(.W(W)) u_next_state (
    .i_state      (r_state),
    .i_data       (bus.in_data),
    .i_pattern    (PATTERN),
    .o_next_state (w_next_state),
    .o_hit        (w_hit)
  );

  // Clear outranks everything else on the edge, including a match completing there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S0;
      r_match <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (bus.clear) begin
      r_state <= S0;
      r_match <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (bus.in_valid) begin
        r_state <= w_next_state;
        if (w_hit) begin
          r_match <= 1'b1;
          if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
          if (r_count >= CNT_NEAR) r_sat <= 1'b1;
        end
      end
    end
  end

  assign bus.match       = r_match;
  assign bus.match_count = r_count;
  assign bus.count_sat   = r_sat;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_nibble_sequence_detector.sv
// Directed bench: table-driven vectors on the default detector plus hand-written
// sequences for reset, overlap, saturation/clear and the shift-register-fed path.
module tb_nibble_sequence_detector;

  logic       clk;
  logic       rst;
  logic       tb_v;
  logic [3:0] tb_d;
  logic       tb_clr;
  logic [3:0] sr [3];

  int n_checks;
  int n_errors;

  nibble_sequence_detector_if #(.W(4), .CNT_W(8)) if_def ();
  nibble_sequence_detector_if #(.W(4), .CNT_W(8)) if_rep ();
  nibble_sequence_detector_if #(.W(4), .CNT_W(2)) if_sat ();
  nibble_sequence_detector_if #(.W(4), .CNT_W(8)) if_sr  ();

  assign if_def.in_valid = tb_v;
  assign if_def.in_data  = tb_d;
  assign if_def.clear    = tb_clr;
  assign if_rep.in_valid = tb_v;
  assign if_rep.in_data  = tb_d;
  assign if_rep.clear    = tb_clr;
  assign if_sat.in_valid = tb_v;
  assign if_sat.in_data  = tb_d;
  assign if_sat.clear    = tb_clr;
  assign if_sr.in_valid  = 1'b1;
  assign if_sr.in_data   = sr[2];
  assign if_sr.clear     = tb_clr;

  nibble_sequence_detector #(.W(4), .CNT_W(8)) dut_def (
    .clock (clk), .reset (rst), .bus (if_def));
  nibble_sequence_detector #(.W(4), .PAT0(4'ha), .PAT1(4'ha), .PAT2(4'ha), .PAT3(4'ha), .CNT_W(8)) dut_rep (
    .clock (clk), .reset (rst), .bus (if_rep));
  nibble_sequence_detector #(.W(4), .CNT_W(2)) dut_sat (
    .clock (clk), .reset (rst), .bus (if_sat));
  nibble_sequence_detector #(.W(4), .CNT_W(8)) dut_sr (
    .clock (clk), .reset (rst), .bus (if_sr));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 3-stage shift register in front of dut_sr
  always @(posedge clk) begin
    sr[0] <= tb_d;
    sr[1] <= sr[0];
    sr[2] <= sr[1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- driver / checker ----------------
  task automatic drive(input logic v, input logic [3:0] d, input logic clr);
    tb_v   = v;
    tb_d   = d;
    tb_clr = clr;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       clr;
    logic       m;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [64];
  int   n_vec;

  task automatic add(input logic v, input logic [3:0] d, input logic clr,
                     input logic m, input logic [7:0] cnt, input logic [1:0] st);
    tbl[n_vec] = '{v, d, clr, m, cnt, st};
    n_vec++;
  endtask

  // ---------------- scoreboard queue for the saturation sequence ----------------
  logic [1:0] exp_q [$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_vec    = 0;
    rst      = 1'b1;
    tb_v     = 1'b0;
    tb_d     = 4'h0;
    tb_clr   = 1'b0;

    // basic a,b,c,d then idle
    add(1, 4'ha, 0, 0, 0, 1); add(1, 4'hb, 0, 0, 0, 2); add(1, 4'hc, 0, 0, 0, 3);
    add(1, 4'hd, 0, 1, 1, 0); add(0, 4'h0, 0, 0, 1, 0);
    // clear, then fallback a,b,a,b,c,d
    add(1, 4'h5, 1, 0, 0, 0);
    add(1, 4'ha, 0, 0, 0, 1); add(1, 4'hb, 0, 0, 0, 2); add(1, 4'ha, 0, 0, 0, 1);
    add(1, 4'hb, 0, 0, 0, 2); add(1, 4'hc, 0, 0, 0, 3); add(1, 4'hd, 0, 1, 1, 0);
    add(1, 4'h0, 1, 0, 0, 0);
    // valid gaps: a,(gap),b,c,(gap x2),d
    add(1, 4'ha, 0, 0, 0, 1); add(0, 4'bx, 0, 0, 0, 1); add(1, 4'hb, 0, 0, 0, 2);
    add(1, 4'hc, 0, 0, 0, 3); add(0, 4'bx, 0, 0, 0, 3); add(0, 4'bx, 0, 0, 0, 3);
    add(1, 4'hd, 0, 1, 1, 0); add(0, 4'bx, 0, 0, 1, 0);
    // mismatch in S3 on 'a' falls back to S1, then a stray nibble to S0; a,a stays S1
    add(1, 4'ha, 0, 0, 1, 1); add(1, 4'hb, 0, 0, 1, 2); add(1, 4'hc, 0, 0, 1, 3);
    add(1, 4'ha, 0, 0, 1, 1); add(1, 4'he, 0, 0, 1, 0); add(1, 4'ha, 0, 0, 1, 1);
    add(1, 4'ha, 0, 0, 1, 1); add(1, 4'hc, 0, 0, 1, 0);
    // clear on the edge a match completes: match dropped
    add(1, 4'ha, 0, 0, 1, 1); add(1, 4'hb, 0, 0, 1, 2); add(1, 4'hc, 0, 0, 1, 3);
    add(1, 4'hd, 1, 0, 0, 0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'(if_def.state), 32'd0);
    chk("reset_match", 32'(if_def.match), 32'd0);
    chk("reset_count", 32'(if_def.match_count), 32'd0);
    chk("reset_sat",   32'(if_sat.count_sat), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk($sformatf("vec%0d_match", i), 32'(if_def.match), 32'(tbl[i].m));
      chk($sformatf("vec%0d_count", i), 32'(if_def.match_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_state", i), 32'(if_def.state), 32'(tbl[i].st));
    end
    tb_clr = 1'b0;

    // reset mid-sequence: build count=1, stream a,b,c, reset between edges
    drive(1, 4'ha, 0); drive(1, 4'hb, 0); drive(1, 4'hc, 0); drive(1, 4'hd, 0);
    chk("pre_reset_count", 32'(if_def.match_count), 32'd1);
    drive(1, 4'ha, 0); drive(1, 4'hb, 0); drive(1, 4'hc, 0);
    chk("pre_reset_state", 32'(if_def.state), 32'd3);
    rst = 1'b1;
    #2;
    chk("midrst_state", 32'(if_def.state), 32'd0);
    chk("midrst_match", 32'(if_def.match), 32'd0);
    chk("midrst_count", 32'(if_def.match_count), 32'd0);
    #1;
    rst = 1'b0;
    drive(1, 4'ha, 0); chk("postrst_m1", 32'(if_def.match), 32'd0);
    drive(1, 4'hb, 0); chk("postrst_m2", 32'(if_def.match), 32'd0);
    drive(1, 4'hc, 0); chk("postrst_m3", 32'(if_def.match), 32'd0);
    drive(1, 4'hd, 0); chk("postrst_m4", 32'(if_def.match), 32'd1);
    chk("postrst_count", 32'(if_def.match_count), 32'd1);

    // overlap with pattern a,a,a,a
    drive(1, 4'h0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'ha, 0);
      chk($sformatf("ovl%0d_match", i), 32'(if_rep.match), (i >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovl%0d_state", i), 32'(if_rep.state), (i >= 3) ? 32'd3 : 32'(i + 1));
    end
    chk("ovl_count", 32'(if_rep.match_count), 32'd3);

    // saturation with a 2-bit counter
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1, 4'h0, 1);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] e;
      drive(1, 4'ha, 0); drive(1, 4'hb, 0); drive(1, 4'hc, 0); drive(1, 4'hd, 0);
      e = exp_q.pop_front();
      chk($sformatf("sat%0d_match", i), 32'(if_sat.match), 32'd1);
      chk($sformatf("sat%0d_count", i), 32'(if_sat.match_count), 32'(e));
      chk($sformatf("sat%0d_flag", i),  32'(if_sat.count_sat), (i >= 2) ? 32'd1 : 32'd0);
    end
    drive(1, 4'ha, 0); drive(1, 4'hb, 0); drive(1, 4'hc, 0);
    chk("sat_hold_flag", 32'(if_sat.count_sat), 32'd1);
    drive(1, 4'hd, 1);
    chk("satclr_match", 32'(if_sat.match), 32'd0);
    chk("satclr_count", 32'(if_sat.match_count), 32'd0);
    chk("satclr_flag",  32'(if_sat.count_sat), 32'd0);
    chk("satclr_state", 32'(if_sat.state), 32'd0);

    // shift-register-fed path: flush, then a,b,c,d arrives three edges later
    drive(1, 4'h0, 1); drive(1, 4'h0, 1); drive(1, 4'h0, 1);
    drive(1, 4'ha, 0); chk("sr_m1", 32'(if_sr.match), 32'd0);
    drive(1, 4'hb, 0); chk("sr_m2", 32'(if_sr.match), 32'd0);
    drive(1, 4'hc, 0); chk("sr_m3", 32'(if_sr.match), 32'd0);
    drive(1, 4'hd, 0); chk("sr_m4", 32'(if_sr.match), 32'd0);
    drive(1, 4'h0, 0); chk("sr_m5", 32'(if_sr.match), 32'd0);
    drive(1, 4'h0, 0); chk("sr_m6", 32'(if_sr.match), 32'd0);
    drive(1, 4'h0, 0); chk("sr_m7", 32'(if_sr.match), 32'd1);
    chk("sr_count", 32'(if_sr.match_count), 32'd1);
    drive(1, 4'h0, 0); chk("sr_m8", 32'(if_sr.match), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
